// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S sample scheduler.
package i2s_pkg;

   localparam int DATA_W_DEF = 12;
   localparam int CNT_W      = 16;

   typedef struct packed {
      logic [DATA_W_DEF-1:0] left;
      logic [DATA_W_DEF-1:0] right;
   } frame_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FILL   = 2'd1,
      ST_STREAM = 2'd2,
      ST_DRAIN  = 2'd3
   } state_e;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

endpackage

// File: rtl/i2s_sample_scheduler_if.sv
// Producer stream and I2S master connections of the sample scheduler.
interface i2s_sample_scheduler_if #(parameter int DATA_W = 12);

   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_left;
   logic [DATA_W-1:0] in_right;
   logic              right_n_left;
   logic              i2s_enable;
   logic [DATA_W-1:0] left_audio;
   logic [DATA_W-1:0] right_audio;

   modport master (
      output in_valid, in_left, in_right, right_n_left,
      input  in_ready, i2s_enable, left_audio, right_audio
   );

   modport slave (
      input  in_valid, in_left, in_right, right_n_left,
      output in_ready, i2s_enable, left_audio, right_audio
   );

endinterface

// File: rtl/i2s_sample_scheduler_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy output.
module stereo_fifo #(
   parameter int WIDTH = 24,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  logic [WIDTH-1:0]         i_wdata,
   output logic [WIDTH-1:0]         o_rdata,
   output logic [$clog2(DEPTH):0]   o_level
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W:0]   r_level;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         if (i_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
            r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
         end
         if (i_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         case ({i_push, i_pop})
            2'b10:   r_level <= r_level + (PTR_W+1)'(1);
            2'b01:   r_level <= r_level - (PTR_W+1)'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   assign o_rdata = r_mem[r_rd_ptr];
   assign o_level = r_level;

endmodule

// File: rtl/i2s_sample_scheduler.sv
// Feeds buffered stereo frames to an I2S master, updating each channel only
// at the slot boundary that follows it.
module i2s_sample_scheduler
   import i2s_pkg::*;
#(
   parameter int DATA_W           = DATA_W_DEF,
   parameter int FIFO_DEPTH       = 8,
   parameter int MUTE_ON_UNDERRUN = 1,
   parameter int START_LEVEL      = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         run,
   i2s_sample_scheduler_if.slave        bus,
   output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
   output logic                         underrun,
   output logic [CNT_W-1:0]             underrun_count
);

   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

   state_e            r_state;
   state_e            w_state_nxt;
   logic              r_sync1, r_sync2, r_hist;
   logic              w_rise, w_fall;
   logic [LVL_W-1:0]  w_level;
   logic [2*DATA_W-1:0] w_head;
   logic              w_push, w_pop, w_in_ready, w_active, w_empty;
   logic [DATA_W-1:0] r_left, r_right, r_pending;
   logic              r_enable, r_underrun;
   logic [CNT_W-1:0]  r_count;

   stereo_fifo #(.WIDTH(2*DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_wdata ({bus.in_left, bus.in_right}),
      .o_rdata (w_head),
      .o_level (w_level)
   );

   // right_n_left is BCLK-derived, so it is resynchronized before edge detection.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_hist  <= 1'b0;
      end else begin
         r_sync1 <= bus.right_n_left;
         r_sync2 <= r_sync1;
         r_hist  <= r_sync2;
      end
   end

   assign w_rise     = r_sync2 & ~r_hist;
   assign w_fall     = ~r_sync2 & r_hist;
   assign w_active   = (r_state == ST_STREAM) || (r_state == ST_DRAIN);
   assign w_empty    = (w_level == '0);
   assign w_in_ready = (w_level < LVL_W'(FIFO_DEPTH)) && ((r_state != ST_IDLE) || run)
                       && (r_state != ST_DRAIN);
   assign w_push     = bus.in_valid & w_in_ready;
   assign w_pop      = w_active & w_rise & ~w_empty;

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (run) w_state_nxt = ST_FILL;
            else     w_state_nxt = ST_IDLE;
         end
         ST_FILL: begin
            if (!run)                                   w_state_nxt = ST_DRAIN;
            else if (w_level >= LVL_W'(START_LEVEL))    w_state_nxt = ST_STREAM;
            else                                        w_state_nxt = ST_FILL;
         end
         ST_STREAM: begin
            if (!run) w_state_nxt = ST_DRAIN;
            else      w_state_nxt = ST_STREAM;
         end
         ST_DRAIN: begin
            if (run)                    w_state_nxt = ST_STREAM;
            else if (w_empty && w_fall) w_state_nxt = ST_IDLE;
            else                        w_state_nxt = ST_DRAIN;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Sample registers, underrun reporting and the master enable.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_left     <= '0;
         r_right    <= '0;
         r_pending  <= '0;
         r_enable   <= 1'b0;
         r_underrun <= 1'b0;
         r_count    <= '0;
      end else begin
         r_enable   <= (w_state_nxt == ST_STREAM) || (w_state_nxt == ST_DRAIN);
         r_underrun <= 1'b0;
         if (r_state == ST_IDLE) begin
            r_left    <= '0;
            r_right   <= '0;
            r_pending <= '0;
         end else if (w_active && w_rise) begin
            if (!w_empty) begin
               r_left    <= w_head[2*DATA_W-1:DATA_W];
               r_pending <= w_head[DATA_W-1:0];
            end else begin
               // A drained queue running dry is expected, so only STREAM counts it.
               if (r_state == ST_STREAM) begin
                  r_underrun <= 1'b1;
                  r_count    <= sat_inc(r_count);
               end
               if (MUTE_ON_UNDERRUN != 0) begin
                  r_left    <= '0;
                  r_pending <= '0;
               end
            end
         end else if (w_active && w_fall) begin
            r_right <= r_pending;
         end
      end
   end

   assign bus.in_ready    = w_in_ready;
   assign bus.i2s_enable  = r_enable;
   assign bus.left_audio  = r_left;
   assign bus.right_audio = r_right;
   assign fifo_level      = w_level;
   assign underrun        = r_underrun;
   assign underrun_count  = r_count;

endmodule

// File: tb/tb_i2s_sample_scheduler.sv
// Scoreboard bench: a muting and a holding scheduler share stimulus; edge monitors check audio.
module tb_i2s_sample_scheduler;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        run = 1'b0;
   logic        rnl = 1'b0;
   logic        in_valid = 1'b0;
   logic [11:0] in_left = 12'h000;
   logic [11:0] in_right = 12'h000;

   logic [3:0]  lvl_m, lvl_h;
   logic        und_m, und_h;
   logic [15:0] cnt_m, cnt_h;

   int n_checks = 0;
   int n_errors = 0;
   int und_cycles_m = 0;
   int und_cycles_h = 0;
   int max_level = 0;
   bit track_level = 1'b0;

   logic [11:0] exp_l_m[$], exp_l_h[$], exp_r_m[$], exp_r_h[$];

   always #5 clk = ~clk;

   i2s_sample_scheduler_if #(.DATA_W(12)) if_m ();
   i2s_sample_scheduler_if #(.DATA_W(12)) if_h ();

   assign if_m.in_valid = in_valid;
   assign if_m.in_left = in_left;
   assign if_m.in_right = in_right;
   assign if_m.right_n_left = rnl;
   assign if_h.in_valid = in_valid;
   assign if_h.in_left = in_left;
   assign if_h.in_right = in_right;
   assign if_h.right_n_left = rnl;

   i2s_sample_scheduler #(.DATA_W(12), .FIFO_DEPTH(8), .MUTE_ON_UNDERRUN(1), .START_LEVEL(2)) dut_m (
      .clk(clk), .rst(rst), .run(run), .bus(if_m),
      .fifo_level(lvl_m), .underrun(und_m), .underrun_count(cnt_m));

   i2s_sample_scheduler #(.DATA_W(12), .FIFO_DEPTH(8), .MUTE_ON_UNDERRUN(0), .START_LEVEL(2)) dut_h (
      .clk(clk), .rst(rst), .run(run), .bus(if_h),
      .fifo_level(lvl_h), .underrun(und_h), .underrun_count(cnt_h));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         if (und_m) und_cycles_m++;
         if (und_h) und_cycles_h++;
         if (track_level && int'(lvl_m) > max_level) max_level = int'(lvl_m);
      end
   end

   // Left channel updates three clocks after right_n_left rises.
   initial begin : mon_left
      forever begin
         @(posedge rnl);
         repeat (3) @(posedge clk);
         @(negedge clk);
         if (exp_l_m.size() == 0 || exp_l_h.size() == 0) begin
            chk("left_unexpected_edge", 32'd1, 32'd0);
         end else begin
            chk("left_audio_mute", 32'(if_m.left_audio), 32'(exp_l_m.pop_front()));
            chk("left_audio_hold", 32'(if_h.left_audio), 32'(exp_l_h.pop_front()));
         end
      end
   end

   initial begin : mon_right
      forever begin
         @(negedge rnl);
         repeat (3) @(posedge clk);
         @(negedge clk);
         if (exp_r_m.size() == 0 || exp_r_h.size() == 0) begin
            chk("right_unexpected_edge", 32'd1, 32'd0);
         end else begin
            chk("right_audio_mute", 32'(if_m.right_audio), 32'(exp_r_m.pop_front()));
            chk("right_audio_hold", 32'(if_h.right_audio), 32'(exp_r_h.pop_front()));
         end
      end
   end

   // Leaves in_valid asserted after acceptance so frames can stream back-to-back.
   task automatic push_frame(input logic [11:0] l, input logic [11:0] r);
      int waited = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_left  = l;
      in_right = r;
      while (!if_m.in_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      chk("push_ready", 32'(if_m.in_ready), 32'd1);
      if (if_m.in_ready) @(posedge clk);
      else in_valid = 1'b0;
   endtask

   task automatic rise_exp(input logic [11:0] m, input logic [11:0] h, input int gap);
      repeat (gap) @(negedge clk);
      exp_l_m.push_back(m);
      exp_l_h.push_back(h);
      rnl = 1'b1;
   endtask

   task automatic fall_exp(input logic [11:0] m, input logic [11:0] h, input int gap);
      repeat (gap) @(negedge clk);
      exp_r_m.push_back(m);
      exp_r_h.push_back(h);
      rnl = 1'b0;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_enable", 32'(if_m.i2s_enable), 32'd0);
      chk("rst_left", 32'(if_m.left_audio), 32'd0);
      chk("rst_right", 32'(if_m.right_audio), 32'd0);
      chk("rst_level", 32'(lvl_m), 32'd0);
      chk("rst_ready", 32'(if_m.in_ready), 32'd0);
      chk("rst_count", 32'(cnt_m), 32'd0);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // Start-up
      run = 1'b1;
      track_level = 1'b1;
      push_frame(12'h111, 12'h222);
      @(negedge clk);
      in_valid = 1'b0;
      chk("start_level1", 32'(lvl_m), 32'd1);
      chk("start_en_after_1", 32'(if_m.i2s_enable), 32'd0);
      push_frame(12'h333, 12'h444);
      @(negedge clk);
      in_valid = 1'b0;
      chk("start_en_fill", 32'(if_m.i2s_enable), 32'd0);
      @(negedge clk);
      chk("start_en_stream", 32'(if_m.i2s_enable), 32'd1);
      rise_exp(12'h111, 12'h111, 20);
      fall_exp(12'h222, 12'h222, 200);
      rise_exp(12'h333, 12'h333, 200);
      fall_exp(12'h444, 12'h444, 200);

      // Steady stream at frame rate
      for (int i = 0; i < 16; i++) begin
         push_frame(12'h500 + 12'(i), 12'hA00 + 12'(i));
         @(negedge clk);
         in_valid = 1'b0;
         rise_exp(12'h500 + 12'(i), 12'h500 + 12'(i), 200);
         fall_exp(12'hA00 + 12'(i), 12'hA00 + 12'(i), 200);
      end
      repeat (20) @(negedge clk);
      track_level = 1'b0;
      chk("steady_max_level_le2", 32'(max_level <= 2), 32'd1);
      chk("steady_count_mute", 32'(cnt_m), 32'd0);
      chk("steady_count_hold", 32'(cnt_h), 32'd0);

      // Underrun after three frames
      push_frame(12'h7A1, 12'h7B1);
      push_frame(12'h7A2, 12'h7B2);
      push_frame(12'h7A3, 12'h7B3);
      @(negedge clk);
      in_valid = 1'b0;
      rise_exp(12'h7A1, 12'h7A1, 20);
      fall_exp(12'h7B1, 12'h7B1, 30);
      rise_exp(12'h7A2, 12'h7A2, 30);
      fall_exp(12'h7B2, 12'h7B2, 30);
      rise_exp(12'h7A3, 12'h7A3, 30);
      fall_exp(12'h7B3, 12'h7B3, 30);
      rise_exp(12'h000, 12'h7A3, 30);
      fall_exp(12'h000, 12'h7B3, 30);
      repeat (20) @(negedge clk);
      chk("underrun_pulse_cycles_mute", 32'(und_cycles_m), 32'd1);
      chk("underrun_pulse_cycles_hold", 32'(und_cycles_h), 32'd1);
      chk("underrun_count_mute", 32'(cnt_m), 32'd1);
      chk("underrun_count_hold", 32'(cnt_h), 32'd1);

      // Backpressure: in_valid held with no channel edges
      for (int i = 0; i < 8; i++) begin
         push_frame(12'hC00 + 12'(i), 12'hD00 + 12'(i));
      end
      @(negedge clk);
      in_left  = 12'hC08;
      in_right = 12'hD08;
      chk("full_level8", 32'(lvl_m), 32'd8);
      chk("full_ready_low", 32'(if_m.in_ready), 32'd0);
      repeat (3) @(negedge clk);
      chk("full_level_held", 32'(lvl_m), 32'd8);
      in_valid = 1'b0;
      rise_exp(12'hC00, 12'hC00, 20);
      repeat (10) @(negedge clk);
      chk("full_pop_level7", 32'(lvl_m), 32'd7);
      chk("full_pop_ready", 32'(if_m.in_ready), 32'd1);
      fall_exp(12'hD00, 12'hD00, 20);
      // Rise with a push landing on the very cycle of the pop
      rise_exp(12'hC01, 12'hC01, 20);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b1;
      in_left  = 12'hC08;
      in_right = 12'hD08;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      chk("pushpop_level7", 32'(lvl_m), 32'd7);
      for (int k = 2; k <= 6; k++) begin
         fall_exp(12'hD00 + 12'(k - 1), 12'hD00 + 12'(k - 1), 20);
         rise_exp(12'hC00 + 12'(k), 12'hC00 + 12'(k), 20);
      end
      fall_exp(12'hD06, 12'hD06, 20);
      repeat (20) @(negedge clk);

      // Drain the last two frames
      chk("drain_level2", 32'(lvl_m), 32'd2);
      run = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("drain_ready_low", 32'(if_m.in_ready), 32'd0);
      chk("drain_enable_kept", 32'(if_m.i2s_enable), 32'd1);
      rise_exp(12'hC07, 12'hC07, 20);
      fall_exp(12'hD07, 12'hD07, 20);
      rise_exp(12'hC08, 12'hC08, 20);
      fall_exp(12'hD08, 12'hD08, 20);
      repeat (10) @(negedge clk);
      chk("idle_enable", 32'(if_m.i2s_enable), 32'd0);
      chk("idle_left", 32'(if_m.left_audio), 32'd0);
      chk("idle_right", 32'(if_m.right_audio), 32'd0);
      chk("idle_right_hold", 32'(if_h.right_audio), 32'd0);
      chk("idle_level", 32'(lvl_m), 32'd0);
      chk("drain_no_count", 32'(cnt_m), 32'd1);

      // Asynchronous reset mid-stream
      run = 1'b1;
      push_frame(12'hE01, 12'hF01);
      push_frame(12'hE02, 12'hF02);
      push_frame(12'hE03, 12'hF03);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("restart_enable", 32'(if_m.i2s_enable), 32'd1);
      rise_exp(12'hE01, 12'hE01, 20);
      fall_exp(12'hF01, 12'hF01, 20);
      repeat (20) @(negedge clk);
      chk("pre_rst_level", 32'(lvl_m), 32'd2);
      @(posedge clk);
      #2;
      run = 1'b0;
      rst = 1'b0;
      #1;
      chk("arst_enable", 32'(if_m.i2s_enable), 32'd0);
      chk("arst_left", 32'(if_m.left_audio), 32'd0);
      chk("arst_right", 32'(if_m.right_audio), 32'd0);
      chk("arst_level", 32'(lvl_m), 32'd0);
      chk("arst_count", 32'(cnt_m), 32'd0);
      chk("arst_ready", 32'(if_m.in_ready), 32'd0);
      repeat (5) @(negedge clk);
      chk("scoreboard_drained",
          32'(exp_l_m.size() + exp_l_h.size() + exp_r_m.size() + exp_r_h.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
